// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with optional hard-wired zero register,
// same-cycle write bypass, synchronous clear and a per-register busy scoreboard.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              read_busy1,
    output logic              read_busy2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] alloc_reg,
    input  logic              alloc_en,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_count;

    logic              w_wr_eff;
    logic              w_al_eff;
    logic              w_inc;
    logic              w_dec;
    logic [DEPTH-1:0]  w_busy_next;

    // Operations aimed at the zero register are dropped entirely.
    assign w_wr_eff = reg_write && !(ZR && (write_reg == '0));
    assign w_al_eff = alloc_en  && !(ZR && (alloc_reg == '0));

    // Count tracks the popcount incrementally; a re-allocation of the
    // register being written back keeps it busy, so no decrement then.
    assign w_inc = w_al_eff && !r_busy[alloc_reg];
    assign w_dec = w_wr_eff && r_busy[write_reg] && !(w_al_eff && (alloc_reg == write_reg));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
            assign w_busy_next[gi] = (w_al_eff && (alloc_reg == ADDR_W'(gi))) ? 1'b1 :
                                     (w_wr_eff && (write_reg == ADDR_W'(gi))) ? 1'b0 :
                                     r_busy[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_eff) begin
            r_regs[write_reg] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_next;
            r_busy_count <= r_busy_count + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
        end
    end

    assign busy_count = r_busy_count;

    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic [1:0]        w_rd_busy;
    logic [1:0]        w_rd_zero;
    logic [1:0]        w_hit;

    assign w_rd_addr[0] = read_reg1;
    assign w_rd_addr[1] = read_reg2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign w_rd_zero[gi] = ZR && (w_rd_addr[gi] == '0);
            assign w_hit[gi]     = BP && reg_write && (write_reg == w_rd_addr[gi]) && !w_rd_zero[gi];
            assign w_rd_data[gi] = w_rd_zero[gi] ? '0 :
                                   w_hit[gi]     ? write_data :
                                   r_regs[w_rd_addr[gi]];
            // A writeback releases the stall this cycle unless a new producer claims it.
            assign w_rd_busy[gi] = r_busy[w_rd_addr[gi]] &&
                                   !(w_hit[gi] && !(alloc_en && (alloc_reg == w_rd_addr[gi])));
        end
    endgenerate

    assign read_data1 = w_rd_data[0];
    assign read_data2 = w_rd_data[1];
    assign read_busy1 = w_rd_busy[0];
    assign read_busy2 = w_rd_busy[1];

endmodule
